memoria_dados: RTL and testbench

Data-memory responder for the processor datapath: receives the 64-bit byte address produced by the address/operation unit (base + OFFSET), then performs a 64-bit load or store with a fixed, configurable latency and a valid/ready handshake. It is the memory-side endpoint of the datapath's load/store path. Completion and load data go back to the control unit as a one-cycle response pulse.

---
 rtl/memoria_pkg.sv | 11 +
 rtl/memoria_dados_if.sv | 23 ++
 rtl/ram_sincrona.sv | 28 ++
 rtl/memoria_dados.sv | 93 +++++++++
 tb/tb_memoria_dados.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/memoria_pkg.sv
// rtl/memoria_pkg.sv - shared widths and FSM state encoding for the data-memory responder
package memoria_pkg;
    localparam int WORD_W = 64;
    localparam int LAT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;
endpackage

// File: rtl/memoria_dados_if.sv
// rtl/memoria_dados_if.sv - request/response bundle between the control unit and the data memory
interface memoria_dados_if;
    import memoria_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [63:0]       req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ram_sincrona.sv
// rtl/ram_sincrona.sv - single-port DEPTH x 64 array, synchronous write and registered read
module ram_sincrona
    import memoria_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WORD_W-1:0]        wdata_i,
    output logic [WORD_W-1:0]        rdata_o
);
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Read data only moves on an enabled access, so it holds until the response.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/memoria_dados.sv
// rtl/memoria_dados.sv - fixed-latency load/store responder; MEMORIA_DADOS_CHECK_EN enables alignment/range errors
module memoria_dados
    import memoria_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    memoria_dados_if.slave   bus
);
    localparam int AW     = $clog2(DEPTH);
    localparam int IDX_HI = AW + 2;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              accept;
    logic              addr_err;
    logic              in_resp;
    logic [WORD_W-1:0] ram_rdata;

`ifdef MEMORIA_DADOS_CHECK_EN
    assign addr_err = (|bus.req_addr[2:0]) || (|bus.req_addr[63:IDX_HI+1]);
`else
    logic unused_addr;
    assign addr_err    = 1'b0;
    assign unused_addr = ^{bus.req_addr[63:IDX_HI+1], bus.req_addr[2:0]};
`endif

    assign accept = bus.req_valid && bus.req_ready;

    ram_sincrona #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .en_i    (accept),
        .we_i    (bus.req_we && !addr_err),
        .addr_i  (bus.req_addr[IDX_HI:3]),
        .wdata_i (bus.req_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d  = bus.req_we;
                    err_d = addr_err;
                    if (LAT == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_W'(LAT - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gating with rst keeps an aborted access from leaking a response pulse.
    assign in_resp        = (state_q == RESP) && !rst;
    assign bus.req_ready  = (state_q == IDLE) && !rst;
    assign bus.resp_valid = in_resp;
    assign bus.resp_err   = in_resp && err_q;
    assign bus.resp_rdata = (in_resp && !we_q && !err_q) ? ram_rdata : '0;
endmodule

// File: tb/tb_memoria_dados.sv
// tb/tb_memoria_dados.sv - self-checking bench for memoria_dados (LAT=2 and LAT=0 instances)
module tb_memoria_dados;
    import memoria_pkg::*;

    localparam int DEPTH  = 256;
    localparam int LAT    = 2;
    localparam int DEPTH0 = 16;
`ifdef MEMORIA_DADOS_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memoria_dados_if bus ();
    memoria_dados_if bus0 ();

    memoria_dados #(.DEPTH(DEPTH), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
    memoria_dados #(.DEPTH(DEPTH0), .LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];
    logic [63:0] model_mem [int];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_err(input logic [63:0] a);
        if (!CHK) return 1'b0;
        return (a % 8 != 0) || ((a / 8) >= DEPTH);
    endfunction

    function automatic int m_idx(input logic [63:0] a);
        return int'((a / 8) % DEPTH);
    endfunction

    // Issue one access on the LAT instance starting at a negedge; returns response fields and latency.
    task automatic access(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                          output logic [63:0] rdata, output logic err, output int lat, output bit ok);
        int  w;
        bit  leak;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        ok = 1'b0; rdata = '0; err = 1'b0; lat = 0;
        if (!bus.req_ready) begin
            chk("accept_timeout", 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_wdata = {$urandom, $urandom};
        lat  = 1;
        leak = 1'b0;
        while (!bus.resp_valid && lat < 30) begin
            if (bus.resp_rdata != 0 || bus.resp_err) leak = 1'b1;
            @(negedge clk);
            lat++;
        end
        ok    = bus.resp_valid;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        chk("quiet_outputs", 64'(leak), 0);
        @(negedge clk);
        chk("resp_one_cycle", 64'(bus.resp_valid), 0);
        chk("idle_outputs", {bus.resp_rdata[62:0], bus.resp_err}, 0);
        chk("ready_after_resp", 64'(bus.req_ready), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        bit          ok;
        bit [15:0]   rdy;
        int          nresp;
        bit          saw;
        logic [63:0] x0;

        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_wdata = '0;
        bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = '0; bus0.req_wdata = '0;

        vecs[0] = '{1'b1, 64'h10,  64'hDEADBEEF_01234567, 64'h0, 1'b0};
        vecs[1] = '{1'b0, 64'h10,  64'h0, 64'hDEADBEEF_01234567, 1'b0};
        vecs[2] = '{1'b1, 64'h13,  64'h1111, 64'h0, CHK};
        vecs[3] = '{1'b0, 64'h10,  64'h0, CHK ? 64'hDEADBEEF_01234567 : 64'h1111, 1'b0};
        vecs[4] = '{1'b1, 64'h0,   64'hA5A5A5A5_5A5A5A5A, 64'h0, 1'b0};
        vecs[5] = '{1'b0, 64'h800, 64'h0, CHK ? 64'h0 : 64'hA5A5A5A5_5A5A5A5A, CHK};
        vecs[6] = '{1'b1, 64'h7F8, 64'h55, 64'h0, 1'b0};
        vecs[7] = '{1'b0, 64'h7F8, 64'h0, 64'h55, 1'b0};

        repeat (3) @(negedge clk);
        chk("ready_in_reset", 64'(bus.req_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 64'(bus.req_ready), 1);
        chk("reset_resp_valid", 64'(bus.resp_valid), 0);
        chk("reset_rdata", bus.resp_rdata, 0);
        chk("reset_err", 64'(bus.resp_err), 0);

        for (int i = 0; i < 8; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat, ok);
            chk($sformatf("vec%0d_resp", i), 64'(ok), 1);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT + 1));
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
            if (vecs[i].we && !m_err(vecs[i].addr)) model_mem[m_idx(vecs[i].addr)] = vecs[i].wdata;
        end

        for (int i = 0; i < 40; i++) begin
            bit          we;
            logic [63:0] a;
            logic [63:0] wd;
            bit          e;
            we = 1'($urandom % 2);
            a  = 64'($urandom % 16) * 8;
            case ($urandom % 8)
                0: a = a | 64'($urandom % 7 + 1);
                1: a = a | (64'h800 << ($urandom % 4));
                default: ;
            endcase
            wd = {$urandom, $urandom};
            e  = m_err(a);
            access(we, a, wd, rd, er, lat, ok);
            chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(LAT + 1));
            chk($sformatf("rnd%0d_err", i), 64'(er), 64'(e));
            if (we || e) begin
                chk($sformatf("rnd%0d_rdata_zero", i), rd, 0);
            end else if (model_mem.exists(m_idx(a))) begin
                chk($sformatf("rnd%0d_rdata", i), rd, model_mem[m_idx(a)]);
            end
            if (we && !e) model_mem[m_idx(a)] = wd;
        end

        // Back-to-back loads with req_valid held high.
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 64'h10;
        nresp = 0;
        rdy   = '0;
        for (int i = 0; i <= 2 * (LAT + 2); i++) begin
            rdy[i] = bus.req_ready;
            if (bus.resp_valid) nresp++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        repeat (LAT + 1) begin
            if (bus.resp_valid) nresp++;
            @(negedge clk);
        end
        for (int i = 0; i <= 2 * (LAT + 2); i++)
            chk($sformatf("b2b_ready_c%0d", i), 64'(rdy[i]), 64'(i % (LAT + 2) == 0));
        chk("b2b_resp_count", 64'(nresp), 3);

        // Reset during WAIT aborts the access.
        saw = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 64'h0;
        chk("rst_mid_accept", 64'(bus.req_ready), 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        saw |= bus.resp_valid;
        @(negedge clk);
        saw |= bus.resp_valid;
        rst = 1'b1;
        @(negedge clk);
        saw |= bus.resp_valid;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready_after", 64'(bus.req_ready), 1);
        chk("rst_mid_outputs", {bus.resp_rdata[61:0], bus.resp_err, bus.resp_valid}, 0);
        repeat (4) begin
            saw |= bus.resp_valid;
            @(negedge clk);
        end
        chk("rst_mid_no_resp", 64'(saw), 0);

        // LAT=0 instance: response in the next cycle, ready the cycle after.
        x0 = {$urandom, $urandom};
        bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 64'h18; bus0.req_wdata = x0;
        chk("lat0_ready", 64'(bus0.req_ready), 1);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        chk("lat0_st_resp", 64'(bus0.resp_valid), 1);
        chk("lat0_st_rdata", bus0.resp_rdata, 0);
        chk("lat0_busy", 64'(bus0.req_ready), 0);
        @(negedge clk);
        chk("lat0_ready_again", 64'(bus0.req_ready), 1);
        chk("lat0_pulse_end", 64'(bus0.resp_valid), 0);
        bus0.req_valid = 1'b1; bus0.req_we = 1'b0;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        chk("lat0_ld_resp", 64'(bus0.resp_valid), 1);
        chk("lat0_ld_rdata", bus0.resp_rdata, x0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
